// File: rtl/in_mapper_mc.sv
// Multi-channel AER -> SpiNNaker MC mapper: round-robin arbiter, channel-tagged keys, circular packet FIFO, dump mode.
// Accept->ipkt_vld 1 cycle; ipkt_rdy low fills the FIFO then drops iaer_rdy. IN_MAPPER_MC_PAYLOAD_EN adds a timestamp payload.
module in_mapper_mc #(
    parameter int NUM_CH      = 4,
    parameter int AER_WIDTH   = 24,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 128,
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 0,
    localparam int LW  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        dump_on,
    input  logic                        dump_off,
    output logic                        dump_mode,
    input  logic [31:0]                 tx_data_mask,
    input  logic [NUM_CH*AER_WIDTH-1:0] iaer_data,
    input  logic [NUM_CH-1:0]           iaer_vld,
    output logic [NUM_CH-1:0]           iaer_rdy,
    output logic [71:0]                 ipkt_data,
    output logic                        ipkt_vld,
    input  logic                        ipkt_rdy,
    output logic [LW-1:0]               fifo_level,
    output logic [15:0]                 drop_cnt
);
    localparam int CHI = (CHW > 0) ? CHW : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
`ifdef IN_MAPPER_MC_PAYLOAD_EN
    localparam int EW = 72;
`else
    localparam int EW = 40;
`endif

    logic           cmd_dump_q, cmd_dump_d;
    logic           dump_mode_q, dump_mode_d;
    logic [15:0]    to_cnt_q, to_cnt_d;
    logic           to_flag_q, to_flag_d;
    logic [CHI-1:0] rr_q, rr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic [EW-1:0]  mem_q [FIFO_DEPTH];

    logic [CHI-1:0]       grant, idx;
    logic                 grant_vld, full, empty, accept, rd_en;
    logic [AER_WIDTH-1:0] sel_dat, masked;
    logic [31:0]          key, payload;
    logic                 pflag, par;
    logic [7:0]           ctrl;
    logic [EW-1:0]        entry;
    logic [16:0]          drop_sum;
    logic                 unused_mask;

    assign unused_mask = ^tx_data_mask;

`ifdef IN_MAPPER_MC_PAYLOAD_EN
    logic [31:0] ts_q, ts_d;
    assign ts_d    = ts_q + 32'd1;
    assign payload = ts_q;
    assign pflag   = 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= 32'd0;
        else        ts_q <= ts_d;
    end
`else
    assign payload = 32'h0;
    assign pflag   = 1'b0;
`endif

    // Descending scan so the last hit is the first valid channel at or after rr_q.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CHI'((int'(rr_q) + i) % NUM_CH);
            if (iaer_vld[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(grant) == c) sel_dat = iaer_data[c*AER_WIDTH +: AER_WIDTH];
        end
    end

    assign masked = sel_dat & tx_data_mask[AER_WIDTH-1:0];

    if (CHW > 0) begin : g_tag
        always_comb begin
            key            = 32'(masked);
            key[31 -: CHW] = grant;
        end
    end else begin : g_notag
        assign key = 32'(masked);
    end

    // Parity bit makes the total number of ones across all 72 bits odd.
    assign par  = ~^{payload, key, 6'b000000, pflag};
    assign ctrl = {6'b000000, pflag, par};

`ifdef IN_MAPPER_MC_PAYLOAD_EN
    assign entry     = {payload, key, ctrl};
    assign ipkt_data = mem_q[rd_ptr_q];
`else
    assign entry     = {key, ctrl};
    assign ipkt_data = {32'h0, mem_q[rd_ptr_q]};
`endif

    assign full   = (level_q == LW'(FIFO_DEPTH));
    assign empty  = (level_q == '0);
    assign accept = enable & ~full & grant_vld & ~dump_mode_q;
    assign rd_en  = ~empty & ipkt_rdy & ~dump_mode_q;

    always_comb begin
        iaer_rdy = '0;
        if (dump_mode_q)                    iaer_rdy = {NUM_CH{enable}};
        else if (enable & ~full & grant_vld) iaer_rdy[grant] = 1'b1;
    end

    assign drop_sum = {1'b0, drop_cnt_q} + 17'($countones(iaer_vld & iaer_rdy));

    always_comb begin
        cmd_dump_d = cmd_dump_q;
        if (dump_off)     cmd_dump_d = 1'b0;
        else if (dump_on) cmd_dump_d = 1'b1;

        to_cnt_d = to_cnt_q;
        if (ipkt_rdy)               to_cnt_d = 16'(TIMEOUT_CYC);
        else if (to_cnt_q != 16'd0) to_cnt_d = to_cnt_q - 16'd1;
        to_flag_d   = ~ipkt_rdy & (to_cnt_q == 16'd0);
        dump_mode_d = cmd_dump_q | to_flag_q;

        rr_d = rr_q;
        if (accept) rr_d = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;

        drop_cnt_d = drop_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (dump_mode_q) begin
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
        end else begin
            if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LW'(accept) - LW'(rd_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_dump_q  <= 1'b1;
            dump_mode_q <= 1'b1;
            to_cnt_q    <= 16'(TIMEOUT_CYC);
            to_flag_q   <= 1'b0;
            rr_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            drop_cnt_q  <= 16'd0;
        end else begin
            cmd_dump_q  <= cmd_dump_d;
            dump_mode_q <= dump_mode_d;
            to_cnt_q    <= to_cnt_d;
            to_flag_q   <= to_flag_d;
            rr_q        <= rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage needs no reset: level/pointers gate every read.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= entry;
    end

    assign dump_mode  = dump_mode_q;
    assign ipkt_vld   = ~empty & ~dump_mode_q;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_in_mapper_mc.sv
// Scoreboard bench for in_mapper_mc: stimulus pushes expected packets, a monitor pops them on each ipkt handshake.
module tb_in_mapper_mc;
    localparam int NUM_CH = 4;
    localparam int AERW   = 24;
    localparam int DEPTH  = 8;
    localparam int TMO    = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        dump_on = 1'b0;
    logic        dump_off = 1'b0;
    logic        dump_mode;
    logic [31:0] tx_data_mask = 32'hFFFF_FFFF;
    logic [95:0] iaer_data;
    logic [3:0]  iaer_vld = 4'h0;
    logic [3:0]  iaer_rdy;
    logic [71:0] ipkt_data;
    logic        ipkt_vld;
    logic        ipkt_rdy = 1'b1;
    logic [3:0]  fifo_level;
    logic [15:0] drop_cnt;

    logic [23:0] chd [4];
    logic [71:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always_comb iaer_data = {chd[3], chd[2], chd[1], chd[0]};

    in_mapper_mc #(.NUM_CH(NUM_CH), .AER_WIDTH(AERW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dump_on(dump_on), .dump_off(dump_off),
        .dump_mode(dump_mode), .tx_data_mask(tx_data_mask), .iaer_data(iaer_data),
        .iaer_vld(iaer_vld), .iaer_rdy(iaer_rdy), .ipkt_data(ipkt_data), .ipkt_vld(ipkt_vld),
        .ipkt_rdy(ipkt_rdy), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
    );

`ifdef IN_MAPPER_MC_PAYLOAD_EN
    logic [31:0] ts_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_m <= 32'd0;
        else        ts_m <= ts_m + 32'd1;
    end
`endif

    // Expected packet for a channel and already-masked data, as seen the cycle before the accepting edge.
    function automatic logic [71:0] exp_pkt(input logic [1:0] ch, input logic [23:0] d);
        logic [31:0] k;
        logic [31:0] pl;
        logic [6:0]  hi;
        k = {ch, 6'b000000, d};
`ifdef IN_MAPPER_MC_PAYLOAD_EN
        pl = ts_m;
        hi = 7'b0000001;
`else
        pl = 32'h0;
        hi = 7'b0000000;
`endif
        return {pl, k, hi, ~^{pl, k, hi}};
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n && ipkt_vld && ipkt_rdy) begin
            chk("sb_parity", 72'(^ipkt_data), 72'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got %0h expected none", ipkt_data);
            end else begin
                chk("sb_pkt", ipkt_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          exp_g [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
        logic [3:0]  oh;
        logic [71:0] head0;
        logic [23:0] md;
        head0 = '0;
        for (int c = 0; c < 4; c++) chd[c] = 24'h0;

        @(negedge clk);
        chk("rst_dump_mode", 72'(dump_mode), 72'd1);
        chk("rst_level", 72'(fifo_level), 72'd0);
        chk("rst_drop", 72'(drop_cnt), 72'd0);
        chk("rst_ipkt_vld", 72'(ipkt_vld), 72'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Leave command dump mode: status follows two edges later.
        dump_off = 1'b1;
        step();
        dump_off = 1'b0;
        step();
        @(negedge clk);
        chk("dump_off", 72'(dump_mode), 72'd0);

        // Test 1: enable gating, then single event on ch2.
        step();
        enable = 1'b0;
        chd[2] = 24'h00ABCD;
        iaer_vld = 4'b0100;
        @(negedge clk);
        chk("rdy_disabled", 72'(iaer_rdy), 72'd0);
        step();
        enable = 1'b1;
        @(negedge clk);
        chk("no_accept_disabled", 72'(fifo_level), 72'd0);
        chk("rdy_grant2", 72'(iaer_rdy), 72'b0100);
        exp_q.push_back(exp_pkt(2'd2, 24'h00ABCD));
        step();
        iaer_vld = 4'h0;
        @(negedge clk);
        chk("t1_vld", 72'(ipkt_vld), 72'd1);
        chk("t1_level", 72'(fifo_level), 72'd1);
`ifndef IN_MAPPER_MC_PAYLOAD_EN
        chk("t1_data", ipkt_data, 72'h00000000_8000ABCD_00);
`endif
        repeat (2) step();

        // Test 2: all channels streaming; rr pointer is at 3 after the ch2 grant.
        chd[0] = 24'h111111; chd[1] = 24'h222222; chd[2] = 24'h333333; chd[3] = 24'h444444;
        iaer_vld = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            oh = 4'h0;
            oh[exp_g[i]] = 1'b1;
            chk("rr_grant", 72'(iaer_rdy), 72'(oh));
            exp_q.push_back(exp_pkt(2'(exp_g[i]), chd[exp_g[i]]));
            step();
        end
        iaer_vld = 4'h0;
        repeat (2) step();

        // Test 3: stalled sink, ch0 streams until FIFO is full, then drains in order.
        tx_data_mask = 32'hFFFF_F0F0;
        ipkt_rdy = 1'b0;
        iaer_vld = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            chd[0] = 24'h0A0000 + 24'(i * 24'h010101);
            @(negedge clk);
            if (i < DEPTH) begin
                chk("fill_rdy", 72'(iaer_rdy), 72'b0001);
                md = chd[0] & tx_data_mask[23:0];
                if (i == 0) head0 = exp_pkt(2'd0, md);
                exp_q.push_back(exp_pkt(2'd0, md));
            end else begin
                chk("full_rdy", 72'(iaer_rdy), 72'd0);
            end
            step();
        end
        iaer_vld = 4'h0;
        @(negedge clk);
        chk("full_level", 72'(fifo_level), 72'd8);
        chk("stall_head", ipkt_data, head0);
        step();
        ipkt_rdy = 1'b1;
        n = 0;
        while (fifo_level != 4'd0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_level", 72'(fifo_level), 72'd0);
        tx_data_mask = 32'hFFFF_FFFF;

        // Test 4: timeout into dump mode with a partly filled FIFO.
        step();
        ipkt_rdy = 1'b0;
        iaer_vld = 4'b0010;
        n = 0;
        repeat (3) begin
            step();
            n++;
        end
        iaer_vld = 4'h0;
        while (!dump_mode && n < 300) begin
            step();
            n++;
        end
        chk("timeout_cycles", 72'(n), 72'(TMO + 2));
        @(negedge clk);
        chk("dump_ipkt_vld", 72'(ipkt_vld), 72'd0);
        step();
        @(negedge clk);
        chk("dump_flush", 72'(fifo_level), 72'd0);
        chk("drop_before", 72'(drop_cnt), 72'd0);
        step();
        iaer_vld = 4'b0101;
        repeat (5) begin
            @(negedge clk);
            chk("dump_rdy", 72'(iaer_rdy), 72'hF);
            step();
        end
        iaer_vld = 4'h0;
        @(negedge clk);
        chk("drop_cnt", 72'(drop_cnt), 72'd10);
        step();
        ipkt_rdy = 1'b1;
        step();
        @(negedge clk);
        chk("recover_1", 72'(dump_mode), 72'd1);
        step();
        @(negedge clk);
        chk("recover_2", 72'(dump_mode), 72'd0);

        // Test 5: dump_off wins over a simultaneous dump_on.
        step();
        dump_on = 1'b1;
        step();
        dump_on = 1'b0;
        step();
        @(negedge clk);
        chk("dump_on", 72'(dump_mode), 72'd1);
        step();
        dump_on = 1'b1;
        dump_off = 1'b1;
        step();
        dump_on = 1'b0;
        dump_off = 1'b0;
        step();
        @(negedge clk);
        chk("on_off_prio", 72'(dump_mode), 72'd0);

        // Asynchronous reset with packets in flight.
        step();
        ipkt_rdy = 1'b0;
        iaer_vld = 4'b1000;
        repeat (2) step();
        @(negedge clk);
        chk("pre_rst_level", 72'(fifo_level), 72'd2);
        chk("pre_rst_vld", 72'(ipkt_vld), 72'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_dump", 72'(dump_mode), 72'd1);
        chk("arst_level", 72'(fifo_level), 72'd0);
        chk("arst_vld", 72'(ipkt_vld), 72'd0);
        chk("arst_drop", 72'(drop_cnt), 72'd0);
        chk("arst_rdy", 72'(iaer_rdy), 72'hF);
        iaer_vld = 4'h0;
        ipkt_rdy = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step();
        chk("sb_leftover", 72'(exp_q.size()), 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
